adder_arb: RTL

ADDER_ARB -- requirements
Module: adder_arb

---
 rtl/adder_arb_pkg.sv | 14 +
 rtl/adder_arb_rca32.sv | 24 ++
 rtl/adder_arb.sv | 112 +++++++++++
 3 files changed

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the two-requester arbitrated adder:
// FSM encoding, default operand width and grant-counter width.
package adder_arb_pkg;

  localparam int ADDER_ARB_WIDTH = 32;
  localparam int CNT_W           = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder_arb_rca32.sv
// Combinational 32-bit ripple-carry adder (module rca32) used as the
// datapath of adder_arb.
module rca32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [32:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 32; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[32];
  end

endmodule

// File: rtl/adder_arb.sv
// Two-requester round-robin arbiter in front of a registered adder.
// Define ADDER_ARB_STATS_EN to add the per-requester grant counters.
//
//   state | meaning
//   IDLE  | waiting for a request; ready driven to the granted requester
//   CALC  | operands latched; adder result registered this cycle
//   RESP  | rsp_valid high, result held until rsp_ready
module adder_arb
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = ADDER_ARB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req0_ci,
  input  logic             req1_ci,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
`ifdef ADDER_ARB_STATS_EN
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic             rsp_co
`else
  output logic             rsp_co
`endif
);

  state_t           state, state_nxt;
  logic             ptr;
  logic             gnt_id;
  logic             accept;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_ci;
  logic [WIDTH-1:0] sum;
  logic             sum_co;

  // ptr holds the last granted id; on a tie the other requester wins
  always_comb begin
    gnt_id     = (req0_valid && req1_valid) ? ~ptr : req1_valid;
    req0_ready = !reset && (state == IDLE) && req0_valid && !gnt_id;
    req1_ready = !reset && (state == IDLE) && req1_valid && gnt_id;
    accept     = req0_ready || req1_ready;
    rsp_valid  = (state == RESP);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= 1'b1;
      op_a   <= '0;
      op_b   <= '0;
      op_ci  <= 1'b0;
      rsp_id <= 1'b0;
      rsp_s  <= '0;
      rsp_co <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ptr    <= gnt_id;
        rsp_id <= gnt_id;
        op_a   <= gnt_id ? req1_a  : req0_a;
        op_b   <= gnt_id ? req1_b  : req0_b;
        op_ci  <= gnt_id ? req1_ci : req0_ci;
      end
      if (state == CALC) begin
        rsp_s  <= sum;
        rsp_co <= sum_co;
      end
    end
  end

  rca32 u_rca32 (
    .a  (op_a),
    .b  (op_b),
    .ci (op_ci),
    .s  (sum),
    .co (sum_co)
  );

`ifdef ADDER_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (req1_ready) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule
